// File: rtl/dac_ramp.sv
// dac_ramp: slew-limited DAC code generator.
// Accepts a target code over a valid/ready handshake. It then walks data_dac
// toward that target in steps of at most `step`, or jumps straight to it when
// ramp_en=0. Updates are spaced so that each SPI frame finishes before the
// next code change.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   tgt_valid    new target offered
//   tgt_ready    high in IDLE: a target can be accepted this cycle
//   tgt_data     target DAC code (unsigned)
//   step         maximum code change per update (0 is treated as 1)
//   ramp_en      1 = slew-limited ramp, 0 = single jump to target
//   data_dac     registered DAC code
//   busy         high while ramping
//   done         one-cycle pulse when data_dac reaches the accepted target
module dac_ramp #(
  parameter int DW           = 14,
  parameter int UPD_INTERVAL = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [DW-1:0] tgt_data,
  input  logic [DW-1:0] step,
  input  logic          ramp_en,
  output logic [DW-1:0] data_dac,
  output logic          busy,
  output logic          done
);

  localparam int            GW      = $clog2(UPD_INTERVAL + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(UPD_INTERVAL);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;

  logic          hs, gap_ok;
  logic [DW:0]   diff, eff_step;

  always_comb begin
    hs       = tgt_valid && (state_q == IDLE);
    gap_ok   = (gap_q == GAP_MAX);
    // One extra bit so the magnitude and the step compare cleanly at full scale.
    diff     = (tgt_q >= data_q) ? ({1'b0, tgt_q} - {1'b0, data_q})
                                 : ({1'b0, data_q} - {1'b0, tgt_q});
    eff_step = (step == '0) ? (DW+1)'(1) : {1'b0, step};

    state_d = state_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Accepting a target only arms the ramp. The first step waits for the
        // next edge, even if the gap counter is already saturated.
        if (hs) begin
          tgt_d = tgt_data;
          if (tgt_data == data_q) done_d  = 1'b1;
          else                    state_d = RAMP;
        end
      end
      RAMP: begin
        if (gap_ok) begin
          if (!ramp_en || (diff <= eff_step)) begin
            data_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (tgt_q > data_q) begin
            data_d = data_q + eff_step[DW-1:0];
          end else begin
            data_d = data_q - eff_step[DW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The gap counter restarts on the cycle data_dac changes. It then counts
    // up to UPD_INTERVAL and holds there, so changes are spaced by at least
    // UPD_INTERVAL+1 edges.
    if (data_d != data_q) gap_d = '0;
    else if (!gap_ok)     gap_d = gap_q + GW'(1);
    else                  gap_d = gap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      tgt_q   <= '0;
      gap_q   <= GAP_MAX;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign data_dac  = data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dac_ramp.sv
// tb_dac_ramp: directed and random target sequences for dac_ramp.
// The reference model gives, for each accepted target, a list of
// (edge number, code) update events. It builds them from the slew rule and the
// minimum spacing between updates. Samples are taken on the falling edge.
module tb_dac_ramp;
  localparam int DW  = 14;
  localparam int UPD = 320;
  localparam int NEVER = -100000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          tgt_valid = 1'b0, ramp_en = 1'b0;
  logic [DW-1:0] tgt_data = '0, step = '0;
  logic          tgt_ready, busy, done;
  logic [DW-1:0] data_dac;

  dac_ramp #(.DW(DW), .UPD_INTERVAL(UPD)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .step(step), .ramp_en(ramp_en),
    .data_dac(data_dac), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  int cur = 0;             // model: current DAC code
  int last_chg = NEVER;    // model: edge of the last data_dac change

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Move to the falling edge that follows rising edge n.
  task automatic go_sample(input int n);
    if (cyc > n) chk("sched", cyc, n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Offer a target, then check every update event the model predicts.
  // With hold=1 the request stays asserted with hold_tgt during the ramp;
  // it must not be accepted until the ramp ends.
  task automatic do_txn(input int tgt, input int stp, input int ren,
                        input bit hold = 1'b0, input int hold_tgt = 0);
    int h, e, v, d, es, p;
    int ev_v[$], ev_e[$];
    chk("ready_pre", tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt_data  = tgt[DW-1:0];
    step      = stp[DW-1:0];
    ramp_en   = ren[0];
    @(negedge clk);
    h = cyc;
    if (hold && tgt != cur) tgt_data = hold_tgt[DW-1:0];
    else                    tgt_valid = 1'b0;
    chk("hs_data", data_dac, cur);
    if (tgt == cur) begin
      chk("eq_done", done, 1);
      chk("eq_busy", busy, 0);
      return;
    end
    chk("hs_busy", busy, 1);
    chk("hs_done", done, 0);
    chk("hs_ready", tgt_ready, 0);
    // Slew rule, one entry per update.
    v = cur;
    e = max2(h + 1, last_chg + UPD + 1);
    forever begin
      d  = (tgt > v) ? tgt - v : v - tgt;
      es = (stp == 0) ? 1 : stp;
      if (ren == 0 || d <= es) v = tgt;
      else if (tgt > v)        v = v + es;
      else                     v = v - es;
      ev_v.push_back(v);
      ev_e.push_back(e);
      if (v == tgt) break;
      e = e + UPD + 1;
    end
    p = cur;
    foreach (ev_v[i]) begin
      go_sample(ev_e[i] - 1);
      chk("pre_val", data_dac, p);
      chk("pre_done", done, 0);
      chk("pre_busy", busy, 1);
      go_sample(ev_e[i]);
      chk("step_val", data_dac, ev_v[i]);
      chk("step_done", done, int'(i == ev_v.size() - 1));
      p = ev_v[i];
    end
    chk("end_busy", busy, 0);
    chk("end_ready", tgt_ready, 1);
    cur      = tgt;
    last_chg = ev_e[ev_e.size() - 1];
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int h, e, t, s, r, d;
    // Reset values while held.
    repeat (3) @(negedge clk);
    chk("rst_data", data_dac, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    do_txn(100, 30, 1);            // 30, 60, 90, 100
    do_txn(0, 40, 1);              // 60, 20, 0
    do_txn(16383, 5, 0);           // jump
    do_txn(16381, 0, 1);           // 16382, 16381
    do_txn(16381, 7, 1);           // equal target
    do_txn(500, 6000, 1, 1'b1, 9000);  // held request waits for IDLE
    do_txn(9000, 4000, 1);

    // Reset between steps.
    chk("mr_ready", tgt_ready, 1);
    tgt_valid = 1'b1; tgt_data = '0; step = 14'd1000; ramp_en = 1'b1;
    @(negedge clk);
    h = cyc;
    tgt_valid = 1'b0;
    e = max2(h + 1, last_chg + UPD + 1);
    go_sample(e + 5);
    chk("mr_pre", data_dac, cur - 1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_data", data_dac, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", tgt_ready, 1);
    chk("mr_done", done, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    cur      = 0;
    last_chg = NEVER;
    do_txn(1234, 1000, 1);         // first step on the edge after handshake

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      t = ($urandom_range(0, 9) == 0) ? cur : int'($urandom_range(0, 16383));
      d = (t > cur) ? t - cur : cur - t;
      r = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if (d <= 3 && $urandom_range(0, 1) == 1) s = 0;
      else s = int'($urandom_range(d / 3 + 1, 16383));
      do_txn(t, s, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dac_ramp.md
DAC_RAMP -- requirements
Module: dac_ramp

Interface
REQ-001 Parameter DW, default 14: width of DAC code and step.
REQ-002 Parameter UPD_INTERVAL, default 512: minimum clk cycles between successive data_dac changes; legal range 320..4095, so one full downstream SPI frame (about 281 cycles) completes between updates.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 tgt_valid  input  1  new target code offered.
REQ-006 tgt_ready  output  1  block accepts a target this cycle.
REQ-007 tgt_data  input  DW  target DAC code, unsigned.
REQ-008 step  input  DW  maximum code change per update, unsigned; sampled at each update.
REQ-009 ramp_en  input  1  1 = slew-limited ramp, 0 = jump straight to target; sampled at each update.
REQ-010 data_dac  output  DW  registered DAC code feeding the SPI serializer.
REQ-011 busy  output  1  high while a ramp is in progress.
REQ-012 done  output  1  one-cycle pulse when data_dac reaches the accepted target.

Function
REQ-013 The state machine SHALL have exactly two states, IDLE and RAMP.
REQ-014 tgt_ready SHALL equal (state==IDLE); a handshake occurs when tgt_valid && tgt_ready.
REQ-015 On a handshake, tgt_data SHALL be latched into an internal target register.
REQ-016 On a handshake, if tgt_data==data_dac, the state SHALL stay IDLE and done SHALL pulse on the next cycle.
REQ-017 On a handshake, if tgt_data!=data_dac, the state SHALL go to RAMP on the next cycle.
REQ-018 busy SHALL equal (state==RAMP).
REQ-019 gap counter: reset to 0 on every cycle data_dac changes, otherwise increments, saturating at UPD_INTERVAL.
REQ-020 gap_ok SHALL be asserted when the gap counter equals UPD_INTERVAL.
REQ-021 In RAMP with gap_ok, data_dac SHALL update once on that clock edge; no update SHALL occur in RAMP without gap_ok.
REQ-022 Update rule: diff = |target - data_dac| computed at DW+1 bits; eff_step = (step==0) ? 1 : step.
REQ-023 If ramp_en==0 or diff<=eff_step, data_dac SHALL be set to target, the state SHALL go to IDLE, and done SHALL pulse in the same cycle the final value appears.
REQ-024 Otherwise data_dac SHALL be set to data_dac+eff_step (target above) or data_dac-eff_step (target below); the result never wraps because diff>eff_step.
REQ-025 Consecutive data_dac changes SHALL be separated by at least UPD_INTERVAL+1 cycles.
REQ-026 A handshake coinciding with gap_ok SHALL only enter RAMP; the first step occurs no earlier than the following cycle.
REQ-027 tgt_valid during RAMP SHALL be ignored (no handshake); the upstream holds the request until tgt_ready.
REQ-028 A new target accepted in IDLE SHALL not be cancelled or retargeted until done.

Reset
REQ-029 While rst_n=0: data_dac=0, state=IDLE, tgt_ready=1, busy=0, done=0, target=0, gap counter=UPD_INTERVAL (so the first update is not delayed).
REQ-030 Reset asserted mid-ramp SHALL immediately force the values in REQ-029; the in-flight target SHALL be discarded.
REQ-031 Release of rst_n SHALL take effect synchronously to clk; the first handshake is possible on the first clk edge after release.

Verification
REQ-032 Reset check: hold rst_n=0 -> data_dac=0, tgt_ready=1, busy=0, done=0.
REQ-033 Up-ramp: from 0, tgt_data=100, step=30, ramp_en=1 -> data_dac 30, 60, 90, 100, spaced exactly UPD_INTERVAL+1 cycles apart (first step 1 cycle after entering RAMP); done pulses with 100; tgt_ready returns high.
REQ-034 Down-ramp: from 100, tgt_data=0, step=40 -> data_dac 60, 20, 0; no underflow; one done pulse.
REQ-035 Jump and step=0: ramp_en=0, tgt_data=16383 -> single update to 16383. Then ramp_en=1, step=0, tgt_data=16381 -> 16382, 16381.
REQ-036 Equal target: tgt_data equal to current data_dac -> no data_dac change, busy stays 0, done pulses 1 cycle after the handshake; tgt_valid held during RAMP is not accepted until IDLE.
REQ-037 Reset mid-ramp: assert rst_n=0 between steps -> data_dac=0 asynchronously; after release a new target is accepted and its first step is immediate (gap counter saturated).
